id_ex_stage: RTL and testbench

ID/EX pipeline stage of the five-stage MIPS pipeline: registers decoded instruction fields from ID and presents fully resolved operands (`alu_a`, `alu_b`, `alu_fun`, `alu_sign`) to the combinational ALU in EX. It provides register-file write bypass at latch time, EX-side forwarding from EX/MEM and MEM/WB, load-use hazard detection (`stall_id`), and bubble insertion on flush.

---
 rtl/mips_pkg.sv | 50 +++++
 rtl/operand_forward.sv | 27 ++
 rtl/id_ex_stage.sv | 164 ++++++++++++++++
 tb/tb_id_ex_stage.sv | 386 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: ALUFun codes, register address width,
// and the layout of the ID/EX pipeline register.
package mips_pkg;

    localparam int REG_AW = 5;
    localparam int XLEN   = 32;

    // Arithmetic
    localparam logic [5:0] ALU_ADD   = 6'b000000;
    localparam logic [5:0] ALU_SUB   = 6'b000001;
    // Logic
    localparam logic [5:0] ALU_AND   = 6'b011000;
    localparam logic [5:0] ALU_OR    = 6'b011110;
    localparam logic [5:0] ALU_XOR   = 6'b010110;
    localparam logic [5:0] ALU_NOR   = 6'b010001;
    localparam logic [5:0] ALU_PASSA = 6'b011010;
    // Shift
    localparam logic [5:0] ALU_SLL   = 6'b100000;
    localparam logic [5:0] ALU_SRL   = 6'b100001;
    localparam logic [5:0] ALU_SRA   = 6'b100011;
    // Compare
    localparam logic [5:0] ALU_EQ    = 6'b110011;
    localparam logic [5:0] ALU_NEQ   = 6'b110001;
    localparam logic [5:0] ALU_LT    = 6'b110101;
    localparam logic [5:0] ALU_LEZ   = 6'b111101;
    localparam logic [5:0] ALU_LTZ   = 6'b111011;
    localparam logic [5:0] ALU_GTZ   = 6'b111111;

    // Contents of the ID/EX register; an all-zero value is a bubble.
    typedef struct packed {
        logic              valid;
        logic [XLEN-1:0]   pc;
        logic [REG_AW-1:0] rs_addr;
        logic [REG_AW-1:0] rt_addr;
        logic [XLEN-1:0]   rs_data;
        logic [XLEN-1:0]   rt_data;
        logic [XLEN-1:0]   imm;
        logic [4:0]        shamt;
        logic [5:0]        alufun;
        logic              sign;
        logic              alusrc1;
        logic              alusrc2;
        logic [REG_AW-1:0] wr_addr;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
        logic              mem_to_reg;
    } id_ex_t;

endpackage

// File: rtl/operand_forward.sv
// Resolves one source operand in EX: the youngest in-flight writer of the
// register (EX/MEM before MEM/WB) supplies the value; $0 is never forwarded.
module operand_forward
    import mips_pkg::*;
(
    input  logic [REG_AW-1:0] addr,
    input  logic [XLEN-1:0]   reg_data,
    input  logic              exm_reg_write,
    input  logic [REG_AW-1:0] exm_wr_addr,
    input  logic [XLEN-1:0]   exm_result,
    input  logic              mwb_reg_write,
    input  logic [REG_AW-1:0] mwb_wr_addr,
    input  logic [XLEN-1:0]   mwb_result,
    output logic [XLEN-1:0]   data
);

    // Priority select: EX/MEM match, then MEM/WB match, then registered value
    always_comb begin
        data = reg_data;
        if (addr != '0 && exm_reg_write && exm_wr_addr == addr) begin
            data = exm_result;
        end else if (addr != '0 && mwb_reg_write && mwb_wr_addr == addr) begin
            data = mwb_result;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline stage: registers decoded fields, bypasses the register file
// write port at latch time, forwards into the ALU operands and raises
// stall_id on data hazards.
// Build option ID_EX_FORWARD_EN: when defined, EX forwarding is active and only
// load-use stalls; when undefined, operands come straight from the register
// and any dependency on ID/EX or EX/MEM stalls.
module id_ex_stage
    import mips_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [REG_AW-1:0] id_rs_addr,
    input  logic [REG_AW-1:0] id_rt_addr,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic [XLEN-1:0]   id_rs_data,
    input  logic [XLEN-1:0]   id_rt_data,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [4:0]        id_shamt,
    input  logic [5:0]        id_alufun,
    input  logic              id_sign,
    input  logic              id_alusrc1,
    input  logic              id_alusrc2,
    input  logic [REG_AW-1:0] id_wr_addr,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic              id_mem_to_reg,
    input  logic              exm_reg_write,
    input  logic [REG_AW-1:0] exm_wr_addr,
    input  logic [XLEN-1:0]   exm_result,
    input  logic              mwb_reg_write,
    input  logic [REG_AW-1:0] mwb_wr_addr,
    input  logic [XLEN-1:0]   mwb_result,
    input  logic              flush,
    output logic [XLEN-1:0]   alu_a,
    output logic [XLEN-1:0]   alu_b,
    output logic [5:0]        alu_fun,
    output logic              alu_sign,
    output logic              ex_valid,
    output logic [XLEN-1:0]   ex_pc,
    output logic [XLEN-1:0]   ex_store_data,
    output logic [REG_AW-1:0] ex_wr_addr,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic              ex_mem_to_reg,
    output logic              stall_id
);

`ifdef ID_EX_FORWARD_EN
    localparam logic FWD_EN = 1'b1;
`else
    localparam logic FWD_EN = 1'b0;
`endif

    id_ex_t          ex_q;
    id_ex_t          ex_d;
    logic [XLEN-1:0] fwd_rs;
    logic [XLEN-1:0] fwd_rt;

    // Hazard detection; flush wins because the ID instruction is being squashed
    always_comb begin
`ifdef ID_EX_FORWARD_EN
        logic load_hit;
        load_hit = ex_q.valid && ex_q.mem_read && ex_q.wr_addr != '0 &&
                   ((id_use_rs && id_rs_addr == ex_q.wr_addr) ||
                    (id_use_rt && id_rt_addr == ex_q.wr_addr));
        stall_id = id_valid && !flush && load_hit;
`else
        logic ex_hit;
        logic exm_hit;
        ex_hit   = ex_q.valid && ex_q.reg_write && ex_q.wr_addr != '0 &&
                   ((id_use_rs && id_rs_addr == ex_q.wr_addr) ||
                    (id_use_rt && id_rt_addr == ex_q.wr_addr));
        exm_hit  = exm_reg_write && exm_wr_addr != '0 &&
                   ((id_use_rs && id_rs_addr == exm_wr_addr) ||
                    (id_use_rt && id_rt_addr == exm_wr_addr));
        stall_id = id_valid && !flush && (ex_hit || exm_hit);
`endif
    end

    // Next register value: bubble on flush/stall, otherwise the ID fields with
    // the register file write port bypassed into the source data
    always_comb begin
        ex_d = '0;
        if (!flush && !stall_id) begin
            ex_d.valid      = id_valid;
            ex_d.pc         = id_pc;
            ex_d.rs_addr    = id_rs_addr;
            ex_d.rt_addr    = id_rt_addr;
            ex_d.rs_data    = id_rs_data;
            ex_d.rt_data    = id_rt_data;
            ex_d.imm        = id_imm;
            ex_d.shamt      = id_shamt;
            ex_d.alufun     = id_alufun;
            ex_d.sign       = id_sign;
            ex_d.alusrc1    = id_alusrc1;
            ex_d.alusrc2    = id_alusrc2;
            ex_d.wr_addr    = id_wr_addr;
            ex_d.reg_write  = id_reg_write;
            ex_d.mem_read   = id_mem_read;
            ex_d.mem_write  = id_mem_write;
            ex_d.mem_to_reg = id_mem_to_reg;
            if (mwb_reg_write && mwb_wr_addr != '0 && mwb_wr_addr == id_rs_addr) begin
                ex_d.rs_data = mwb_result;
            end
            if (mwb_reg_write && mwb_wr_addr != '0 && mwb_wr_addr == id_rt_addr) begin
                ex_d.rt_data = mwb_result;
            end
        end
    end

    // Pipeline register with synchronous reset to a bubble
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_q <= '0;
        end else begin
            ex_q <= ex_d;
        end
    end

    // Forwarding is disabled by masking the write enables, which leaves the
    // registered value selected
    operand_forward u_fwd_rs (
        .addr          (ex_q.rs_addr),
        .reg_data      (ex_q.rs_data),
        .exm_reg_write (FWD_EN & exm_reg_write),
        .exm_wr_addr   (exm_wr_addr),
        .exm_result    (exm_result),
        .mwb_reg_write (FWD_EN & mwb_reg_write),
        .mwb_wr_addr   (mwb_wr_addr),
        .mwb_result    (mwb_result),
        .data          (fwd_rs)
    );

    operand_forward u_fwd_rt (
        .addr          (ex_q.rt_addr),
        .reg_data      (ex_q.rt_data),
        .exm_reg_write (FWD_EN & exm_reg_write),
        .exm_wr_addr   (exm_wr_addr),
        .exm_result    (exm_result),
        .mwb_reg_write (FWD_EN & mwb_reg_write),
        .mwb_wr_addr   (mwb_wr_addr),
        .mwb_result    (mwb_result),
        .data          (fwd_rt)
    );

    assign alu_a         = ex_q.alusrc1 ? {{(XLEN-5){1'b0}}, ex_q.shamt} : fwd_rs;
    assign alu_b         = ex_q.alusrc2 ? ex_q.imm : fwd_rt;
    assign alu_fun       = ex_q.alufun;
    assign alu_sign      = ex_q.sign;
    assign ex_valid      = ex_q.valid;
    assign ex_pc         = ex_q.pc;
    assign ex_store_data = fwd_rt;
    assign ex_wr_addr    = ex_q.wr_addr;
    assign ex_reg_write  = ex_q.reg_write;
    assign ex_mem_read   = ex_q.mem_read;
    assign ex_mem_write  = ex_q.mem_write;
    assign ex_mem_to_reg = ex_q.mem_to_reg;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios followed by random
// traffic, all compared against a behavioural model of the stage.
`timescale 1ns/1ps
module tb_id_ex_stage;
    import mips_pkg::*;

`ifdef ID_EX_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [4:0]  id_rs_addr, id_rt_addr;
    logic        id_use_rs, id_use_rt;
    logic [31:0] id_rs_data, id_rt_data, id_imm;
    logic [4:0]  id_shamt;
    logic [5:0]  id_alufun;
    logic        id_sign, id_alusrc1, id_alusrc2;
    logic [4:0]  id_wr_addr;
    logic        id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
    logic        exm_reg_write;
    logic [4:0]  exm_wr_addr;
    logic [31:0] exm_result;
    logic        mwb_reg_write;
    logic [4:0]  mwb_wr_addr;
    logic [31:0] mwb_result;
    logic        flush;
    logic [31:0] alu_a, alu_b;
    logic [5:0]  alu_fun;
    logic        alu_sign;
    logic        ex_valid;
    logic [31:0] ex_pc, ex_store_data;
    logic [4:0]  ex_wr_addr;
    logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
    logic        stall_id;

    id_ex_stage dut (
        .clk(clk), .reset(reset),
        .id_valid(id_valid), .id_pc(id_pc),
        .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
        .id_imm(id_imm), .id_shamt(id_shamt), .id_alufun(id_alufun),
        .id_sign(id_sign), .id_alusrc1(id_alusrc1), .id_alusrc2(id_alusrc2),
        .id_wr_addr(id_wr_addr), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .id_mem_to_reg(id_mem_to_reg),
        .exm_reg_write(exm_reg_write), .exm_wr_addr(exm_wr_addr), .exm_result(exm_result),
        .mwb_reg_write(mwb_reg_write), .mwb_wr_addr(mwb_wr_addr), .mwb_result(mwb_result),
        .flush(flush),
        .alu_a(alu_a), .alu_b(alu_b), .alu_fun(alu_fun), .alu_sign(alu_sign),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_store_data(ex_store_data),
        .ex_wr_addr(ex_wr_addr), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_mem_to_reg(ex_mem_to_reg), .stall_id(stall_id)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- model ----------------
    // The instruction the bench believes is sitting in EX.
    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [4:0]  rs, rt;
        logic [31:0] rs_val, rt_val, imm;
        logic [4:0]  shamt;
        logic [5:0]  fun;
        logic        sign, src1, src2;
        logic [4:0]  wr;
        logic        rw, mr, mw, m2r;
    } mdl_t;

    mdl_t exp_q[$];
    mdl_t cur;
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Value of register r as seen in EX: newest in-flight result, else held value.
    function automatic logic [31:0] mdl_operand(input logic [4:0] r, input logic [31:0] held);
        if (!FWD || r == 5'd0) return held;
        if (exm_reg_write && exm_wr_addr == r) return exm_result;
        if (mwb_reg_write && mwb_wr_addr == r) return mwb_result;
        return held;
    endfunction

    // Does the ID instruction depend on a producer whose value is not yet usable?
    function automatic logic mdl_stall(input mdl_t e);
        logic [4:0] producers[$];
        logic       hit;
        hit = 1'b0;
        if (!id_valid || flush) return 1'b0;
        if (FWD) begin
            if (e.valid && e.mr) producers.push_back(e.wr);
        end else begin
            if (e.valid && e.rw) producers.push_back(e.wr);
            if (exm_reg_write) producers.push_back(exm_wr_addr);
        end
        foreach (producers[i]) begin
            if (producers[i] != 5'd0 &&
                ((id_use_rs && id_rs_addr == producers[i]) ||
                 (id_use_rt && id_rt_addr == producers[i])))
                hit = 1'b1;
        end
        return hit;
    endfunction

    // What EX should hold after the coming edge.
    function automatic mdl_t mdl_latch();
        mdl_t n;
        n = '0;
        if (reset || flush || mdl_stall(cur)) return n;
        n.valid  = id_valid;
        n.pc     = id_pc;
        n.rs     = id_rs_addr;
        n.rt     = id_rt_addr;
        n.rs_val = (mwb_reg_write && mwb_wr_addr != 0 && mwb_wr_addr == id_rs_addr) ? mwb_result : id_rs_data;
        n.rt_val = (mwb_reg_write && mwb_wr_addr != 0 && mwb_wr_addr == id_rt_addr) ? mwb_result : id_rt_data;
        n.imm    = id_imm;
        n.shamt  = id_shamt;
        n.fun    = id_alufun;
        n.sign   = id_sign;
        n.src1   = id_alusrc1;
        n.src2   = id_alusrc2;
        n.wr     = id_wr_addr;
        n.rw     = id_reg_write;
        n.mr     = id_mem_read;
        n.mw     = id_mem_write;
        n.m2r    = id_mem_to_reg;
        return n;
    endfunction

    // ---------------- scoreboard ----------------
    task automatic settle_and_check();
        logic [31:0] exp_a, exp_b, exp_rt;
        #1;
        cur    = exp_q.pop_front();
        exp_rt = mdl_operand(cur.rt, cur.rt_val);
        exp_a  = cur.src1 ? {27'd0, cur.shamt} : mdl_operand(cur.rs, cur.rs_val);
        exp_b  = cur.src2 ? cur.imm : exp_rt;
        check_eq("alu_a", alu_a, exp_a);
        check_eq("alu_b", alu_b, exp_b);
        check_eq("alu_fun", 32'(alu_fun), 32'(cur.fun));
        check_eq("alu_sign", 32'(alu_sign), 32'(cur.sign));
        check_eq("ex_valid", 32'(ex_valid), 32'(cur.valid));
        check_eq("ex_pc", ex_pc, cur.pc);
        check_eq("ex_store_data", ex_store_data, exp_rt);
        check_eq("ex_wr_addr", 32'(ex_wr_addr), 32'(cur.wr));
        check_eq("ex_ctrl", 32'({ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg}),
                 32'({cur.rw, cur.mr, cur.mw, cur.m2r}));
        check_eq("stall_id", 32'(stall_id), 32'(mdl_stall(cur)));
    endtask

    task automatic advance();
        mdl_t nxt;
        nxt = mdl_latch();
        @(posedge clk);
        exp_q.push_back(nxt);
        @(negedge clk);
    endtask

    // ---------------- drivers ----------------
    task automatic drive_idle();
        id_valid = 0; id_pc = 0; id_rs_addr = 0; id_rt_addr = 0;
        id_use_rs = 0; id_use_rt = 0; id_rs_data = 0; id_rt_data = 0;
        id_imm = 0; id_shamt = 0; id_alufun = 0; id_sign = 0;
        id_alusrc1 = 0; id_alusrc2 = 0; id_wr_addr = 0;
        id_reg_write = 0; id_mem_read = 0; id_mem_write = 0; id_mem_to_reg = 0;
    endtask

    task automatic drive_fwd_idle();
        exm_reg_write = 0; exm_wr_addr = 0; exm_result = 0;
        mwb_reg_write = 0; mwb_wr_addr = 0; mwb_result = 0;
        flush = 0;
    endtask

    task automatic drive_exm(input logic we, input logic [4:0] a, input logic [31:0] d);
        exm_reg_write = we; exm_wr_addr = a; exm_result = d;
    endtask

    task automatic drive_mwb(input logic we, input logic [4:0] a, input logic [31:0] d);
        mwb_reg_write = we; mwb_wr_addr = a; mwb_result = d;
    endtask

    task automatic drive_instr(input logic [31:0] pc, input logic [4:0] rs, input logic [4:0] rt,
                               input logic [4:0] wr, input logic [31:0] rs_d, input logic [31:0] rt_d,
                               input logic [31:0] imm, input logic [4:0] shamt, input logic [5:0] fun,
                               input logic src1, input logic src2, input logic use_rs,
                               input logic use_rt, input logic rw, input logic mr);
        id_valid = 1; id_pc = pc; id_rs_addr = rs; id_rt_addr = rt; id_wr_addr = wr;
        id_rs_data = rs_d; id_rt_data = rt_d; id_imm = imm; id_shamt = shamt;
        id_alufun = fun; id_sign = 0; id_alusrc1 = src1; id_alusrc2 = src2;
        id_use_rs = use_rs; id_use_rt = use_rt;
        id_reg_write = rw; id_mem_read = mr; id_mem_write = 0; id_mem_to_reg = mr;
    endtask

    task automatic drive_random();
        id_valid      = ($urandom_range(0, 9) != 0);
        id_pc         = $urandom;
        id_rs_addr    = 5'($urandom_range(0, 7));
        id_rt_addr    = 5'($urandom_range(0, 7));
        id_use_rs     = 1'($urandom_range(0, 1));
        id_use_rt     = 1'($urandom_range(0, 1));
        id_rs_data    = $urandom;
        id_rt_data    = $urandom;
        id_imm        = $urandom;
        id_shamt      = 5'($urandom_range(0, 31));
        id_alufun     = 6'($urandom_range(0, 63));
        id_sign       = 1'($urandom_range(0, 1));
        id_alusrc1    = ($urandom_range(0, 3) == 0);
        id_alusrc2    = 1'($urandom_range(0, 1));
        id_wr_addr    = 5'($urandom_range(0, 7));
        id_reg_write  = 1'($urandom_range(0, 1));
        id_mem_read   = ($urandom_range(0, 2) == 0);
        id_mem_write  = ($urandom_range(0, 3) == 0);
        id_mem_to_reg = id_mem_read;
        if (!id_valid) begin
            id_reg_write = 0; id_mem_read = 0; id_mem_write = 0; id_mem_to_reg = 0;
        end
        drive_exm(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
        drive_mwb(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
        flush = ($urandom_range(0, 9) == 0);
        reset = ($urandom_range(0, 49) == 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        // Reset held two cycles with arbitrary ID inputs
        drive_random();
        drive_fwd_idle();
        reset = 1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        exp_q.push_back('0);
        settle_and_check();
        check_eq("reset_alu_a", alu_a, 32'h0);
        check_eq("reset_alu_b", alu_b, 32'h0);
        check_eq("reset_ex_valid", 32'(ex_valid), 32'h0);
        advance();
        reset = 0;

        // sll $2,$1,7 with $1 = 1
        drive_instr(32'h100, 5'd0, 5'd1, 5'd2, 32'h0, 32'h1, 32'h0, 5'd7, ALU_SLL, 1, 0, 0, 1, 1, 0);
        settle_and_check(); advance();
        drive_idle();
        settle_and_check();
        check_eq("sll_alu_a", alu_a, 32'h7);
        check_eq("sll_alu_b", alu_b, 32'h1);
        check_eq("sll_alu_fun", 32'(alu_fun), 32'(ALU_SLL));
        advance();

        // add $3,$1,$2 ; sub $4,$3,$1 with $3 produced as 0x10
        drive_instr(32'h200, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 32'h0, 5'd0, ALU_ADD, 0, 0, 1, 1, 1, 0);
        settle_and_check(); advance();
        drive_instr(32'h204, 5'd3, 5'd1, 5'd4, 32'h0, 32'h1, 32'h0, 5'd0, ALU_SUB, 0, 0, 1, 1, 1, 0);
        settle_and_check();
        check_eq("dep_stall_c1", 32'(stall_id), FWD ? 32'h0 : 32'h1);
        advance();
`ifdef ID_EX_FORWARD_EN
        drive_idle();
        drive_exm(1, 5'd3, 32'h10);
        settle_and_check();
        check_eq("dep_fwd_alu_a", alu_a, 32'h10);
        check_eq("dep_fwd_alu_fun", 32'(alu_fun), 32'(ALU_SUB));
        advance();
`else
        drive_exm(1, 5'd3, 32'h10);
        settle_and_check();
        check_eq("dep_stall_c2", 32'(stall_id), 32'h1);
        advance();
        drive_exm(0, 5'd0, 32'h0);
        drive_mwb(1, 5'd3, 32'h10);
        settle_and_check();
        check_eq("dep_stall_c3", 32'(stall_id), 32'h0);
        advance();
        drive_idle();
        drive_mwb(0, 5'd0, 32'h0);
        settle_and_check();
        check_eq("dep_bypass_alu_a", alu_a, 32'h10);
        check_eq("dep_bypass_alu_fun", 32'(alu_fun), 32'(ALU_SUB));
        advance();
`endif
        drive_fwd_idle();

        // lw $5 followed by a use of $5
        drive_instr(32'h300, 5'd1, 5'd5, 5'd5, 32'h0, 32'h0, 32'h40, 5'd0, ALU_ADD, 0, 1, 1, 0, 1, 1);
        settle_and_check(); advance();
        drive_instr(32'h304, 5'd5, 5'd0, 5'd7, 32'h0, 32'h0, 32'h0, 5'd0, ALU_ADD, 0, 0, 1, 1, 1, 0);
        settle_and_check();
        check_eq("lu_stall", 32'(stall_id), 32'h1);
        advance();
        drive_exm(1, 5'd5, 32'h140);
        settle_and_check();
        check_eq("lu_bubble", 32'(ex_valid), 32'h0);
        check_eq("lu_stall_after", 32'(stall_id), FWD ? 32'h0 : 32'h1);
        advance();
        drive_exm(0, 5'd0, 32'h0);
        drive_mwb(1, 5'd5, 32'hDEADBEEF);
`ifdef ID_EX_FORWARD_EN
        drive_idle();
        settle_and_check();
        check_eq("lu_fwd_alu_a", alu_a, 32'hDEADBEEF);
        advance();
`else
        settle_and_check();
        advance();
        drive_idle();
        drive_mwb(0, 5'd0, 32'h0);
        settle_and_check();
        check_eq("lu_bypass_alu_a", alu_a, 32'hDEADBEEF);
        advance();
`endif
        drive_fwd_idle();

        // $6 written by both EX/MEM (0xAA) and MEM/WB (0xBB)
        drive_instr(32'h400, 5'd0, 5'd6, 5'd9, 32'h0, 32'h11, 32'h0, 5'd0, ALU_ADD, 0, 0, 1, 1, 1, 0);
        settle_and_check(); advance();
        drive_idle();
        drive_exm(1, 5'd6, 32'hAA);
        drive_mwb(1, 5'd6, 32'hBB);
        settle_and_check();
        check_eq("prio_alu_b", alu_b, FWD ? 32'hAA : 32'h11);
        advance();

        // Writes to $0 are never forwarded or bypassed
        drive_fwd_idle();
        drive_mwb(1, 5'd0, 32'h55);
        drive_instr(32'h500, 5'd0, 5'd0, 5'd10, 32'h0, 32'h0, 32'h0, 5'd0, ALU_OR, 0, 0, 1, 1, 1, 0);
        settle_and_check(); advance();
        drive_idle();
        drive_exm(1, 5'd0, 32'h55);
        settle_and_check();
        check_eq("r0_alu_a", alu_a, 32'h0);
        check_eq("r0_store", ex_store_data, 32'h0);
        advance();

        // Flush while a stall condition holds
        drive_fwd_idle();
        drive_instr(32'h600, 5'd1, 5'd5, 5'd5, 32'h0, 32'h0, 32'h8, 5'd0, ALU_ADD, 0, 1, 1, 0, 1, 1);
        settle_and_check(); advance();
        drive_instr(32'h604, 5'd5, 5'd0, 5'd7, 32'h0, 32'h0, 32'h0, 5'd0, ALU_ADD, 0, 0, 1, 1, 1, 0);
        flush = 1;
        settle_and_check();
        check_eq("flush_stall", 32'(stall_id), 32'h0);
        advance();
        flush = 0;
        drive_idle();
        settle_and_check();
        check_eq("flush_bubble", 32'(ex_valid), 32'h0);
        advance();

        // Random traffic
        for (int i = 0; i < 500; i++) begin
            drive_random();
            settle_and_check();
            advance();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // Time bound on the whole run
    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog got=timeout exp=finish");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
